// File: rtl/flaf_phi_combiner_pkg.sv
// Shared FLAF definitions: combiner FSM states, accumulator sizing, Q-format
// rounding constant and saturation limits.
package flaf_phi_combiner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_RND,
        ST_HOLD
    } comb_state_t;

    localparam int Q_ORD_DEF = 7;
    localparam int WIDTH_DEF = 16;
    localparam int QP_DEF    = 15;

    // Headroom of clog2(q_ord) bits keeps the sum of full-scale products exact.
    function automatic int acc_width(input int width, input int q_ord);
        return 2 * width + $clog2(q_ord);
    endfunction

    function automatic longint round_const(input int qp);
        return longint'(1) << (qp - 1);
    endfunction

    function automatic longint sat_max(input int width);
        return (longint'(1) << (width - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int width);
        return -(longint'(1) << (width - 1));
    endfunction

    localparam int ACC_W_DEF = acc_width(WIDTH_DEF, Q_ORD_DEF);

endpackage

// File: rtl/flaf_phi_combiner_round_sat.sv
// flaf_round_sat: round-half-up of a wide accumulator down to WIDTH bits.
// Saturating clamp when FLAF_COMB_SAT_EN is defined, two's-complement wrap otherwise.
module flaf_round_sat
    import flaf_phi_combiner_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int QP    = QP_DEF
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [WIDTH-1:0] y
);

    localparam logic signed [ACC_W-1:0] RND_K = ACC_W'(round_const(QP));
    localparam logic        [WIDTH-1:0] Y_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic        [WIDTH-1:0] Y_MIN = WIDTH'(sat_min(WIDTH));

    logic signed [ACC_W-1:0] r;
    logic        [WIDTH-1:0] y_trunc;
    logic                    unused_bits;

    assign r           = acc + RND_K;
    assign y_trunc     = r[QP +: WIDTH];
    assign unused_bits = ^{r[QP-1:0], r[ACC_W-1:QP+WIDTH]};

`ifdef FLAF_COMB_SAT_EN
    // Slice is exact only when every bit above it repeats its sign bit.
    logic [ACC_W-QP-WIDTH:0] hi;
    logic                    ovf;

    assign hi  = r[ACC_W-1:QP+WIDTH-1];
    assign ovf = !((&hi) || (~|hi));

    always_comb begin
        y = y_trunc;
        if (ovf) begin
            y = r[ACC_W-1] ? Y_MIN : Y_MAX;
        end
    end
`else
    assign y = y_trunc;
`endif

endmodule

// File: rtl/flaf_phi_combiner.sv
// Sequential weighted combiner y = sum w[k]*phi[k] using one shared multiplier.
// Output saturation is enabled by defining FLAF_COMB_SAT_EN.
module flaf_phi_combiner
    import flaf_phi_combiner_pkg::*;
#(
    parameter int Q_ORD = Q_ORD_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int QP    = QP_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [Q_ORD*WIDTH-1:0] phi_packed,
    input  logic [Q_ORD*WIDTH-1:0] w_packed,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       y_out
);

    localparam int ACC_W = acc_width(WIDTH, Q_ORD);
    localparam int IDX_W = $clog2(Q_ORD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(Q_ORD - 1);

    comb_state_t state, state_nxt;

    logic        [Q_ORD*WIDTH-1:0] phi_reg;
    logic        [Q_ORD*WIDTH-1:0] w_reg;
    logic signed [ACC_W-1:0]       acc;
    logic        [IDX_W-1:0]       idx;
    logic signed [WIDTH-1:0]       phi_sel;
    logic signed [WIDTH-1:0]       w_sel;
    logic signed [2*WIDTH-1:0]     prod;
    logic        [WIDTH-1:0]       y_rs;

    assign phi_sel = phi_reg[WIDTH*int'(idx) +: WIDTH];
    assign w_sel   = w_reg[WIDTH*int'(idx) +: WIDTH];
    assign prod    = phi_sel * w_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid)        state_nxt = ST_MAC;
            ST_MAC:  if (idx == IDX_LAST) state_nxt = ST_RND;
            ST_RND:                       state_nxt = ST_HOLD;
            ST_HOLD: if (out_ready)       state_nxt = ST_IDLE;
            default:                      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phi_reg <= '0;
            w_reg   <= '0;
            acc     <= '0;
            idx     <= '0;
            y_out   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        phi_reg <= phi_packed;
                        w_reg   <= w_packed;
                        acc     <= '0;
                        idx     <= '0;
                    end
                end
                ST_MAC: begin
                    acc <= acc + {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
                    // Parking idx at 0 keeps the term select in range outside MAC.
                    idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end
                ST_RND: y_out <= y_rs;
                default: ;
            endcase
        end
    end

    flaf_round_sat #(
        .ACC_W (ACC_W),
        .WIDTH (WIDTH),
        .QP    (QP)
    ) u_round_sat (
        .acc (acc),
        .y   (y_rs)
    );

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_HOLD);

endmodule

// File: tb/tb_flaf_phi_combiner.sv
// Directed bench for flaf_phi_combiner: latency, rounding, overflow handling,
// backpressure, input isolation while busy and mid-MAC reset.
module tb_flaf_phi_combiner;

    localparam int Q = 7;
    localparam int W = 16;

`ifdef FLAF_COMB_SAT_EN
    localparam logic [W-1:0] EXP_OVF_POS = 16'h7FFF;
    localparam logic [W-1:0] EXP_ONE     = 16'h7FFF;
    localparam logic [W-1:0] EXP_NEG     = 16'h8000;
`else
    localparam logic [W-1:0] EXP_OVF_POS = 16'hE000;
    localparam logic [W-1:0] EXP_ONE     = 16'h8000;
    localparam logic [W-1:0] EXP_NEG     = 16'h8007;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [Q*W-1:0] phi_packed = '0;
    logic [Q*W-1:0] w_packed = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W-1:0]   y_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    flaf_phi_combiner #(
        .Q_ORD (Q),
        .WIDTH (W),
        .QP    (15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .phi_packed (phi_packed),
        .w_packed   (w_packed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y_out      (y_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [Q*W-1:0] fill(input logic [W-1:0] v);
        logic [Q*W-1:0] f;
        for (int k = 0; k < Q; k++) f[W*k +: W] = v;
        return f;
    endfunction

    function automatic logic [Q*W-1:0] one(input int k, input logic [W-1:0] v);
        logic [Q*W-1:0] f;
        f = '0;
        f[W*k +: W] = v;
        return f;
    endfunction

    // Presents one vector pair; scrambles the inputs while busy to prove latching.
    task automatic run_txn(input string tag, input logic [Q*W-1:0] phi, input logic [Q*W-1:0] w,
                           input logic [W-1:0] exp_y, input int stall);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, " ready_wait"}, 32'(in_ready), 32'd1);
        phi_packed = phi;
        w_packed   = w;
        in_valid   = 1'b1;
        out_ready  = (stall == 0);
        @(negedge clk);
        in_valid   = 1'b0;
        phi_packed = ~phi;
        w_packed   = fill(16'h7FFF) ^ w;
        check({tag, " busy"}, 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 30) begin
            @(negedge clk);
            n++;
            phi_packed = {phi_packed[Q*W-2:0], ~phi_packed[Q*W-1]};
        end
        check({tag, " latency"}, 32'(n), 32'd8);
        check({tag, " y"}, 32'(y_out), 32'(exp_y));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, " hold"}, 32'({in_ready, out_valid, y_out}), 32'({1'b0, 1'b1, exp_y}));
        end
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, " drop"}, 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        logic seen_valid;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_state", 32'({in_ready, out_valid, y_out}), 32'({1'b1, 1'b0, 16'h0000}));

        run_txn("basic",      one(0, 16'h4000), one(0, 16'h2000), 16'h1000, 0);
        run_txn("rnd_up",     one(0, 16'h0001), one(0, 16'h4000), 16'h0001, 0);
        run_txn("rnd_down",   one(0, 16'h0001), one(0, 16'h3FFF), 16'h0000, 0);
        run_txn("rnd_neg",    one(0, 16'hFFFF), one(0, 16'h4000), 16'h0000, 0);
        run_txn("last_term",  one(6, 16'h2000), one(6, 16'h7FFF), 16'h2000, 0);
        run_txn("sum_175",    fill(16'h4000), fill(16'h4000),     EXP_OVF_POS, 0);
        run_txn("plus_one",   one(0, 16'h8000), one(0, 16'h8000), EXP_ONE, 0);
        run_txn("neg_full",   fill(16'h8000), fill(16'h7FFF),     EXP_NEG, 0);
        run_txn("backpress",  one(0, 16'h4000), one(0, 16'h2000), 16'h1000, 5);

        // Abort a transaction after the idx=3 update; nothing may be emitted.
        @(negedge clk);
        phi_packed = fill(16'h4000);
        w_packed   = fill(16'h4000);
        in_valid   = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_reset", 32'({out_valid, in_ready, y_out}), 32'({1'b0, 1'b1, 16'h0000}));
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        check("no_partial", 32'(seen_valid), 32'd0);

        run_txn("after_rst",  one(1, 16'hC000), one(1, 16'h4000), 16'hE000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
